// File: rtl/legv8_imm_encoder_if.sv
`default_nettype none
// legv8_imm_encoder_if: request/response bundle for the LEGv8 immediate encoder.
// Rev 1.0 - initial release.
interface legv8_imm_encoder_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_kind;
   logic [4:0]       in_rt;
   logic [4:0]       in_rn;
   logic [63:0]      in_imm;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_word;
   logic             out_err;
   logic [CNT_W-1:0] cnt_ok;
   logic [CNT_W-1:0] cnt_err;

   modport master (
      output in_valid, in_kind, in_rt, in_rn, in_imm, out_ready,
      input  in_ready, out_valid, out_word, out_err, cnt_ok, cnt_err
   );

   modport slave (
      input  in_valid, in_kind, in_rt, in_rn, in_imm, out_ready,
      output in_ready, out_valid, out_word, out_err, cnt_ok, cnt_err
   );
endinterface
`default_nettype wire

// File: rtl/legv8_imm_encoder.sv
`default_nettype none
// legv8_imm_encoder: packs CBZ/LDUR/STUR immediates into LEGv8 words via a 2-entry FIFO.
// Rev 1.0 - initial release.
module legv8_imm_encoder #(
   parameter int CNT_W = 16
) (
   input  wire logic       clk,
   input  wire logic       reset_n,
   legv8_imm_encoder_if.slave bus
);
   localparam logic [1:0] c_KIND_CBZ  = 2'd0;
   localparam logic [1:0] c_KIND_LDUR = 2'd1;
   localparam logic [1:0] c_KIND_STUR = 2'd2;

   logic [1:0]       r_occ;
   logic             r_wp;
   logic             r_rp;
   logic             r_in_ready;
   logic [31:0]      r_word [2];
   logic             r_err  [2];
   logic [CNT_W-1:0] r_cnt_ok;
   logic [CNT_W-1:0] r_cnt_err;

   logic        w_cbz_ok;
   logic        w_ls_ok;
   logic [31:0] w_enc;
   logic        w_bad;
   logic        w_push;
   logic        w_pop;
   logic [1:0]  w_occ_nxt;

   // An offset fits when every bit above the field's sign bit copies it.
   assign w_cbz_ok = (&bus.in_imm[63:18]) | ~(|bus.in_imm[63:18]);
   assign w_ls_ok  = (&bus.in_imm[63:8])  | ~(|bus.in_imm[63:8]);

   always_comb begin
      w_enc = 32'h0;
      w_bad = 1'b1;
      case (bus.in_kind)
         c_KIND_CBZ: begin
            if (w_cbz_ok) begin
               w_bad = 1'b0;
               w_enc = {8'b10110100, bus.in_imm[18:0], bus.in_rt};
            end
         end
         c_KIND_LDUR: begin
            if (w_ls_ok) begin
               w_bad = 1'b0;
               w_enc = {11'b11111000010, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rt};
            end
         end
         c_KIND_STUR: begin
            if (w_ls_ok) begin
               w_bad = 1'b0;
               w_enc = {11'b11111000000, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rt};
            end
         end
         default: begin
            w_bad = 1'b1;
            w_enc = 32'h0;
         end
      endcase
   end

   assign w_push = bus.in_valid & r_in_ready;
   assign w_pop  = (r_occ != 2'd0) & bus.out_ready;

   always_comb begin
      w_occ_nxt = r_occ;
      case ({w_push, w_pop})
         2'b10:   w_occ_nxt = r_occ + 2'd1;
         2'b01:   w_occ_nxt = r_occ - 2'd1;
         default: w_occ_nxt = r_occ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_occ      <= 2'd0;
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
         r_in_ready <= 1'b0;
         r_word[0]  <= 32'h0;
         r_word[1]  <= 32'h0;
         r_err[0]   <= 1'b0;
         r_err[1]   <= 1'b0;
         r_cnt_ok   <= '0;
         r_cnt_err  <= '0;
      end else begin
         r_occ      <= w_occ_nxt;
         r_in_ready <= (w_occ_nxt != 2'd2);
         if (w_push) begin
            r_word[r_wp] <= w_enc;
            r_err[r_wp]  <= w_bad;
            r_wp         <= ~r_wp;
            if (w_bad) begin
               if (!(&r_cnt_err)) r_cnt_err <= r_cnt_err + 1'b1;
            end else begin
               if (!(&r_cnt_ok)) r_cnt_ok <= r_cnt_ok + 1'b1;
            end
         end
         if (w_pop) begin
            r_rp <= ~r_rp;
         end
      end
   end

   // Head is gated so stale slots never leak out while the FIFO is empty.
   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = (r_occ != 2'd0);
   assign bus.out_word  = (r_occ != 2'd0) ? r_word[r_rp] : 32'h0;
   assign bus.out_err   = (r_occ != 2'd0) ? r_err[r_rp]  : 1'b0;
   assign bus.cnt_ok    = r_cnt_ok;
   assign bus.cnt_err   = r_cnt_err;
endmodule
`default_nettype wire

// File: doc/legv8_imm_encoder.md
LEGV8_IMM_ENCODER -- requirements
Module: legv8_imm_encoder

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating accept and reject counters.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  request present.
REQ-005 Port: in_ready  output  1  request accepted this cycle when in_valid && in_ready.
REQ-006 Port: in_kind  input  2  0=CBZ, 1=LDUR, 2=STUR, 3=illegal.
REQ-007 Port: in_rt  input  5  Rt field.
REQ-008 Port: in_rn  input  5  Rn field; ignored for CBZ.
REQ-009 Port: in_imm  input  64  signed offset: instruction words for CBZ, bytes for LDUR/STUR.
REQ-010 Port: out_valid  output  1  encoded word available.
REQ-011 Port: out_ready  input  1  consumer takes the word when out_valid && out_ready.
REQ-012 Port: out_word  output  32  encoded LEGv8 instruction.
REQ-013 Port: out_err  output  1  entry rejected, because of an illegal kind or an immediate out of range.
REQ-014 Port: cnt_ok  output  CNT_W  count of accepted good entries; saturates at all-ones.
REQ-015 Port: cnt_err  output  CNT_W  count of accepted rejected entries; saturates at all-ones.

Function
REQ-016 The block is the inverse of the sign extender: for every good entry, sign-extending the immediate field of out_word to 64 bits SHALL reproduce in_imm exactly.
REQ-017 CBZ encoding SHALL be: [31:24]=8'b10110100, [23:5]=in_imm[18:0], [4:0]=in_rt.
REQ-018 LDUR encoding SHALL be: [31:21]=11'b11111000010, [20:12]=in_imm[8:0], [11:10]=2'b00, [9:5]=in_rn, [4:0]=in_rt.
REQ-019 STUR encoding SHALL be identical to LDUR, except [31:21]=11'b11111000000.
REQ-020 Range check for CBZ SHALL pass iff in_imm[63:18] are all equal (range -262144..262143).
REQ-021 Range check for LDUR/STUR SHALL pass iff in_imm[63:8] are all equal (range -256..255).
REQ-022 A failing range check or in_kind=3 SHALL produce out_word=32'h0 and out_err=1; the entry is still queued and emitted, never dropped.
REQ-023 Encoding and the range check SHALL be computed combinationally from the in_* ports and written into a 2-entry output FIFO on the accepting edge.
REQ-024 Latency: an entry accepted at edge N SHALL be visible at the FIFO head no earlier than after edge N, i.e. one cycle when the FIFO is empty.
REQ-025 in_ready SHALL be a registered function: 1 iff FIFO occupancy < 2; it SHALL NOT depend combinationally on out_ready.
REQ-026 out_valid SHALL be 1 iff occupancy > 0; out_word and out_err SHALL reflect the head entry.
REQ-027 out_word and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-029 Occupancy 1 with push and no pop SHALL go to 2, deasserting in_ready on the next cycle.
REQ-030 Pop from occupancy 2 SHALL re-assert in_ready on the next cycle.
REQ-031 Entries SHALL leave in strict acceptance order.
REQ-032 The FIFO read and write pointers SHALL wrap modulo 2.
REQ-033 On each accept, the counters SHALL update: cnt_ok+1 if good, else cnt_err+1; both saturate and never wrap.

Reset
REQ-034 While reset_n=0: occupancy=0, out_valid=0, in_ready=0, out_word=0, out_err=0, cnt_ok=0, cnt_err=0.
REQ-035 in_ready SHALL rise on the first clk edge after reset_n deasserts.
REQ-036 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.

Verification
REQ-037 CBZ: in_kind=0, rt=3, imm=-4 -> out_word=0xB4FFFF83, out_err=0, cnt_ok=1.
REQ-038 LDUR: in_kind=1, rt=1, rn=2, imm=8 -> out_word=0xF8408041, out_err=0.
REQ-039 Range limits:
  - STUR imm=255 -> 0xF80FF000 | fields, out_err=0.
  - STUR imm=256 -> out_word=0, out_err=1, cnt_err=1.
  - CBZ imm=262144 -> out_err=1.
REQ-040 Backpressure: out_ready=0, offer 3 valid requests -> 2 accepted, then in_ready=0 and the 3rd stalls; raise out_ready -> all 3 emerge in order, with no gaps once streaming.
REQ-041 Reset mid-stream: occupancy=2, pulse reset_n low between edges -> out_valid=0 immediately; counters=0; in_ready=1 one edge after release.
REQ-042 Random round-trip: 10k random kinds, registers and immediates with random out_ready -> every good word, decoded by the sign extender, equals the original imm, and the final counters equal the scoreboard totals.
